// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// Booth digit values and the three-bit digit decoder.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      DIG_ZERO = 3'd0,
      DIG_POS1 = 3'd1,
      DIG_POS2 = 3'd2,
      DIG_NEG1 = 3'd3,
      DIG_NEG2 = 3'd4
   } booth_digit_t;

   // Bits are {y[2i+1], y[2i], y[2i-1]}.
   function automatic booth_digit_t booth_decode(input logic [2:0] bits);
      case (bits)
         3'b001, 3'b010: return DIG_POS1;
         3'b011:         return DIG_POS2;
         3'b100:         return DIG_NEG2;
         3'b101, 3'b110: return DIG_NEG1;
         default:        return DIG_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/result handshake bundle for booth_seq_mult.
interface booth_seq_mult_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
   logic                 mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;

   modport master (
      output in_valid, x, y, mode, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, x, y, mode, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/booth_r4_pp.sv
// Combinational radix-4 Booth partial product: selects 0/+-X/+-2X, shifts by
// two bits per digit index and optionally clears the low APPROX_K columns.
module booth_r4_pp
   import booth_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int APPROX_K = 4,
   parameter int IDX_W    = 2
) (
   input  logic [WIDTH-1:0]   x,
   input  logic [2:0]         digit,
   input  logic [IDX_W-1:0]   idx,
   input  logic               mask_en,
   output logic [2*WIDTH-1:0] pp
);
   localparam int PW = 2 * WIDTH;
   // One extra bit so APPROX_K == 2*WIDTH still yields an all-ones mask.
   localparam logic [PW:0]   MASK_EXT = ((PW+1)'(1) << APPROX_K) - (PW+1)'(1);
   localparam logic [PW-1:0] LOW_MASK = MASK_EXT[PW-1:0];

   logic [PW-1:0] x_ext;
   logic [PW-1:0] mag;
   logic [PW-1:0] shifted;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      x_ext   = {{WIDTH{x[WIDTH-1]}}, x};
      mag     = '0;
      case (booth_decode(digit))
         DIG_POS1: mag = x_ext;
         DIG_POS2: mag = x_ext << 1;
         DIG_NEG1: mag = ~x_ext + PW'(1);
         DIG_NEG2: mag = ~(x_ext << 1) + PW'(1);
         default:  mag = '0;
      endcase
      shifted = mag << {idx, 1'b0};
      pp      = mask_en ? (shifted & ~LOW_MASK) : shifted;
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per clock, WIDTH/2 clocks per
// product, with an optional approximate mode that drops low partial-product columns.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int APPROX_K = 4
) (
   input  logic            clk,
   input  logic            rst,
   booth_seq_mult_if.slave bus
);
   localparam int N     = WIDTH / 2;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   state_t               state;
   logic [IDX_W-1:0]     cnt;
   logic [WIDTH-1:0]     x_q;
   logic [WIDTH-1:0]     y_q;
   logic                 mode_q;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   p_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 busy_q;

   logic [WIDTH:0]       y_ext;
   logic [2:0]           digit;
   logic [2*WIDTH-1:0]   pp;
   logic [2*WIDTH-1:0]   acc_next;

   // The appended zero supplies y[-1] for the first digit.
   assign y_ext    = {y_q, 1'b0};
   assign digit    = y_ext[{cnt, 1'b0} +: 3];
   assign acc_next = acc + pp;

   booth_r4_pp #(
      .WIDTH    (WIDTH),
      .APPROX_K (APPROX_K),
      .IDX_W    (IDX_W)
   ) u_pp (
      .x       (x_q),
      .digit   (digit),
      .idx     (cnt),
      .mask_en (mode_q),
      .pp      (pp)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         mode_q      <= 1'b0;
         acc         <= '0;
         p_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_q        <= bus.x;
                  y_q        <= bus.y;
                  mode_q     <= bus.mode;
                  cnt        <= '0;
                  acc        <= '0;
                  state      <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + IDX_W'(1);
               if (cnt == LAST) begin
                  state       <= DONE;
                  p_q         <= acc_next;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  p_q         <= '0;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               p_q         <= '0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.p         = p_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH = 8, APPROX_K = 4): directed
// literal cases plus a randomized regression against an arithmetic model.
`timescale 1ns/1ps
module tb_booth_seq_mult;

   logic clk = 1'b0;
   logic rst;

   booth_seq_mult_if #(.WIDTH(8)) bus ();

   booth_seq_mult #(
      .WIDTH    (8),
      .APPROX_K (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_vec    = 0;
   bit          mon_en   = 1'b0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Exact mode is the plain signed product; approximate mode sums the Booth
   // digit values d_i in {-2..2} times x, shifted by 2i, low 4 bits dropped.
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
      logic [8:0]  yb;
      logic [15:0] sum;
      logic [15:0] term;
      int          d;
      if (!m) return 16'(int'($signed(a)) * int'($signed(b)));
      yb  = {b, 1'b0};
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         d         = (yb[2*i+2] ? -2 : 0) + (yb[2*i+1] ? 1 : 0) + (yb[2*i] ? 1 : 0);
         term      = 16'((d * int'($signed(a))) <<< (2 * i));
         term[3:0] = 4'b0;
         sum       = sum + term;
      end
      return sum;
   endfunction

   // Per-cycle compare against the expected-result queue.
   always @(negedge clk) begin
      if (mon_en) begin
         check("in_ready_vs_busy", {31'b0, bus.in_ready}, {31'b0, !bus.busy});
         if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("out_valid_without_txn", {31'b0, bus.out_valid}, 32'd0);
            end else begin
               check("p_vs_model", {16'b0, bus.p}, {16'b0, exp_q[0]});
               check("busy_in_done", {31'b0, bus.busy}, 32'd1);
               if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
            end
         end else begin
            check("p_zero_when_not_done", {16'b0, bus.p}, 32'd0);
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (bus.in_ready !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
   endtask

   // Scramble inputs while a product is in flight; none of it may be taken.
   task automatic garble();
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.x        = 8'($urandom);
      bus.y        = 8'($urandom);
      bus.mode     = 1'($urandom_range(0, 1));
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input int hold, input bit has_lit, input logic [15:0] lit,
                        input string name);
      int          lat;
      logic [15:0] p_seen;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.x        = a;
      bus.y        = b;
      bus.mode     = m;
      @(posedge clk); #1;
      exp_q.push_back(model(a, b, m));
      n_vec++;
      if (has_lit) check({name, "_model_pin"}, {16'b0, model(a, b, m)}, {16'b0, lit});
      lat = 0;
      do begin
         garble();
         @(posedge clk); #1;
         lat++;
      end while (bus.out_valid !== 1'b1 && lat < 20);
      bus.in_valid = 1'b0;
      check({name, "_latency"}, lat, 32'd4);
      if (has_lit) check({name, "_p"}, {16'b0, bus.p}, {16'b0, lit});
      p_seen = bus.p;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, "_hold_p"}, {16'b0, bus.p}, {16'b0, p_seen});
         check({name, "_hold_out_valid"}, {31'b0, bus.out_valid}, 32'd1);
         check({name, "_hold_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({name, "_release_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
      check({name, "_release_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
   endtask

   function automatic logic [7:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 8'h80;
         1:       return 8'h7F;
         2:       return 8'hFF;
         3:       return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("reset_busy", {31'b0, bus.busy}, 32'd0);
      check("reset_p", {16'b0, bus.p}, 32'd0);
      mon_en = 1'b1;

      do_op(8'(-34),  8'(100),  1'b0, 0, 1'b1, 16'hF2B8, "exact_m34x100");
      do_op(8'(-13),  8'(12),   1'b0, 0, 1'b1, 16'hFF64, "exact_m13x12");
      do_op(8'(45),   8'(-13),  1'b0, 1, 1'b1, 16'hFDB7, "exact_45xm13");
      do_op(8'(-128), 8'(-128), 1'b0, 0, 1'b1, 16'h4000, "corner_m128xm128");
      do_op(8'(-128), 8'(127),  1'b0, 0, 1'b1, 16'hC080, "corner_m128x127");
      do_op(8'(0),    8'(-1),   1'b0, 0, 1'b1, 16'h0000, "corner_0xm1");
      do_op(8'(1),    8'(1),    1'b1, 0, 1'b1, 16'h0000, "approx_1x1");
      do_op(8'(-1),   8'(1),    1'b1, 0, 1'b1, 16'hFFF0, "approx_m1x1");
      do_op(8'(7),    8'(-9),   1'b0, 10, 1'b1, 16'hFFC1, "backpressure");

      // Abort in the second RUN cycle; no result may ever appear for it.
      wait_ready();
      bus.in_valid = 1'b1;
      bus.x        = 8'(-50);
      bus.y        = 8'(77);
      bus.mode     = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_p", {16'b0, bus.p}, 32'd0);
      repeat (6) @(posedge clk);
      #1;
      do_op(8'(-25), 8'(15), 1'b0, 0, 1'b1, 16'hFE89, "after_abort_m25x15");

      for (int i = 0; i < 1000; i++) begin
         ra = pick_operand();
         rb = pick_operand();
         do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, 16'h0, "rnd");
      end

      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 Parameter APPROX_K, default 4, number of LSB columns masked per partial product in approximate mode; SHALL satisfy 0 <= APPROX_K <= 2*WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and mode are presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 x  input  WIDTH  signed multiplicand, two's complement.
REQ-008 y  input  WIDTH  signed multiplier, two's complement.
REQ-009 mode  input  1  0 = exact product, 1 = approximate product.
REQ-010 out_valid  output  1  p holds a finished result.
REQ-011 out_ready  input  1  consumer accepts p.
REQ-012 p  output  2*WIDTH  signed product.
REQ-013 busy  output  1  high in RUN and DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 Acceptance occurs on an edge where in_valid && in_ready; x, y and mode SHALL be latched, the digit counter cleared, the accumulator zeroed, and the state set to RUN.
REQ-016 RUN SHALL process one radix-4 Booth digit per edge, LSB digit first, for exactly N = WIDTH/2 digits; digit i is taken from bits (y[2i+1], y[2i], y[2i-1]), where y[-1] = 0.
REQ-017 Digit encoding: 000/111 -> 0, 001/010 -> +X, 011 -> +2X, 100 -> -2X, 101/110 -> -X; negation SHALL be exact two's complement (invert plus one).
REQ-018 Each partial product SHALL be sign-extended to 2*WIDTH bits and shifted left by 2i before it is added; accumulation is modulo 2^(2*WIDTH).
REQ-019 With latched mode = 1, bits [APPROX_K-1:0] of each shifted partial product SHALL be cleared before the add; with mode = 0, or with APPROX_K = 0, p SHALL equal the exact x*y.
REQ-020 The edge that processes digit N-1 SHALL move the state to DONE; out_valid rises exactly N edges after the accepting edge.
REQ-021 In DONE, p SHALL hold stable until out_valid && out_ready; on that edge the state SHALL return to IDLE.
REQ-022 The block SHALL NOT accept new operands in RUN or DONE; in_valid in those states SHALL be ignored, with no state change.
REQ-023 Changes to x, y or mode after acceptance SHALL NOT affect the result in flight.
REQ-024 Corner operands (-2^(WIDTH-1) for either or both operands) SHALL give the correct signed result; (-128)*(-128) = 16384 at WIDTH = 8 does not overflow.
REQ-025 When not in DONE, p SHALL read as zero.

Reset
REQ-026 When rst = 1 on an edge, the state SHALL go to IDLE, and the counter, accumulator, latched operands and p SHALL be cleared.
REQ-027 After reset: in_ready = 1, out_valid = 0, busy = 0, p = 0.
REQ-028 Reset in RUN or DONE SHALL abort the operation without ever raising out_valid for it.
REQ-029 rst SHALL take priority over the handshake in the same cycle.

Structure
REQ-030 A shared package booth_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the Booth digit typedef with its five encodings.
REQ-031 A combinational sub-module booth_r4_pp SHALL take X, the three-bit digit, the digit index and the mask enable, and SHALL produce the shifted, masked 2*WIDTH partial product.
REQ-032 booth_seq_mult SHALL contain the FSM, the counter, the operand registers and the accumulator.

Verification (WIDTH = 8, APPROX_K = 4)
REQ-033 Exact products: x = -34, y = 100, mode = 0 -> p = -3400 (0xF2B8); -13*12 -> -156; 45*(-13) -> -585; with out_valid exactly 4 edges after acceptance.
REQ-034 Corner operands: (-128)*(-128) -> 16384; (-128)*127 -> -16256; 0*(-1) -> 0.
REQ-035 Approximate mode: x = 1, y = 1, mode = 1 -> p = 0; x = -1, y = 1, mode = 1 -> p = -16 (0xFFF0).
REQ-036 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> p and out_valid stay stable and in_ready stays 0; out_ready = 1 -> IDLE on the next edge.
REQ-037 Reset in the 2nd RUN cycle -> IDLE on the next edge with out_valid never asserted; the next transaction, -25*15, -> p = -375.
REQ-038 Random regression of 1000 vectors in both modes, compared against a bit-accurate model of REQ-016..REQ-019.
